// File: rtl/ca_grid_engine.sv
// Double-buffered ROWSxCOLS cellular-automaton engine: the front grid is edited and read,
// a generation is computed one cell per clock into the back grid, then committed.
module ca_grid_engine #(
    parameter  int ROWS = 8,
    parameter  int COLS = 8,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS),
    localparam int N    = ROWS * COLS,
    localparam int PW   = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          step,
    input  logic          wrap_en,
    input  logic          nbr8_en,
    input  logic          edit_en,
    input  logic          edit_val,
    input  logic [RW-1:0] edit_row,
    input  logic [CW-1:0] edit_col,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic          rd_state,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] pop_count,
    output logic [15:0]   gen_count
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t        state;
    logic [N-1:0]  front;
    logic [N-1:0]  back;
    logic [RW-1:0] scan_r;
    logic [CW-1:0] scan_c;
    logic          mode_wrap;
    logic          mode_nbr8;

    logic [IW-1:0] scan_idx;
    logic [IW-1:0] edit_idx;
    logic [IW-1:0] rd_idx;
    logic          edit_ok;
    logic          rd_ok;
    logic          cur_cell;
    logic          next_cell;
    logic [3:0]    nbr_cnt;

    // Off-grid neighbours either wrap to the opposite edge or read as dead.
    function automatic logic cell_at(input logic [N-1:0] grid, input int r, input int c,
                                     input logic wrap);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (wrap) begin
            if (rr < 0) rr = ROWS - 1;
            else if (rr >= ROWS) rr = 0;
            if (cc < 0) cc = COLS - 1;
            else if (cc >= COLS) cc = 0;
        end
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
        return grid[IW'(rr * COLS + cc)];
    endfunction

    function automatic logic [PW-1:0] count_live(input logic [N-1:0] grid);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) n = n + PW'(grid[i]);
        return n;
    endfunction

    always_comb begin
        scan_idx = IW'(int'(scan_r) * COLS + int'(scan_c));
        edit_idx = IW'(int'(edit_row) * COLS + int'(edit_col));
        rd_idx   = IW'(int'(rd_row) * COLS + int'(rd_col));
        edit_ok  = (int'(edit_row) < ROWS) && (int'(edit_col) < COLS);
        rd_ok    = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
        cur_cell = front[scan_idx];
        nbr_cnt  = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && (mode_nbr8 || dr == 0 || dc == 0))
                    nbr_cnt = nbr_cnt + 4'(cell_at(front, int'(scan_r) + dr,
                                                   int'(scan_c) + dc, mode_wrap));
            end
        end
        if (mode_nbr8)
            next_cell = cur_cell ? (nbr_cnt == 4'd2 || nbr_cnt == 4'd3) : (nbr_cnt == 4'd3);
        else
            next_cell = cur_cell ? (nbr_cnt == 4'd1 || nbr_cnt == 4'd2) : (nbr_cnt == 4'd2);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            front     <= '0;
            back      <= '0;
            scan_r    <= '0;
            scan_c    <= '0;
            mode_wrap <= 1'b0;
            mode_nbr8 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_state  <= 1'b0;
            pop_count <= '0;
            gen_count <= '0;
        end else begin
            done     <= 1'b0;
            rd_state <= rd_ok ? front[rd_idx] : 1'b0;
            case (state)
                IDLE: begin
                    // Edit lands at this edge, so a step accepted at the same edge scans it.
                    if (edit_en && edit_ok) begin
                        front[edit_idx] <= edit_val;
                        if (edit_val && !front[edit_idx])
                            pop_count <= pop_count + PW'(1);
                        else if (!edit_val && front[edit_idx])
                            pop_count <= pop_count - PW'(1);
                    end
                    if (step) begin
                        mode_wrap <= wrap_en;
                        mode_nbr8 <= nbr8_en;
                        scan_r    <= '0;
                        scan_c    <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    back[scan_idx] <= next_cell;
                    if (scan_c == CW'(COLS - 1)) begin
                        scan_c <= '0;
                        if (scan_r == RW'(ROWS - 1)) state <= COMMIT;
                        else scan_r <= scan_r + RW'(1);
                    end else begin
                        scan_c <= scan_c + CW'(1);
                    end
                end
                COMMIT: begin
                    front     <= back;
                    pop_count <= count_live(back);
                    gen_count <= gen_count + 16'd1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
